alu_div: RTL and testbench
==========================

ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit accepts request; high only in IDLE.
REQ-006 SHALL have ports A, B  input  DATA_WIDTH  dividend, divisor.
REQ-007 SHALL have port is_signed  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have ports Quotient, Remainder  output  DATA_WIDTH  results.
REQ-011 SHALL have ports DivZero, Overflow, Zero  output  1  B==0; signed MIN/-1; Quotient==0.

Function
REQ-012 SHALL implement FSM IDLE, CALC, FIX, DONE.
REQ-013 Accept = in_valid & in_ready in cycle T; SHALL latch A, B, is_signed and go to CALC.
REQ-014 On accept SHALL load |A|, |B| (abs only when is_signed, operand MSB set), record quotient sign = A.msb^B.msb and remainder sign = A.msb, clear iteration counter.
REQ-015 CALC SHALL perform one restoring step per cycle: shift partial remainder left by one taking next dividend bit, trial-subtract |B|, keep result and set quotient bit 1 if no borrow, else restore and set 0.
REQ-016 CALC SHALL last exactly DATA_WIDTH cycles, then go to FIX.
REQ-017 FIX SHALL negate quotient/remainder per recorded signs, then go to DONE; out_valid SHALL first assert in cycle T+DATA_WIDTH+2.
REQ-018 Sign rules: remainder sign follows dividend; quotient truncates toward zero (-7/2 = -3 rem -1).
REQ-019 B==0: Quotient SHALL be all-ones, Remainder SHALL be original A, DivZero=1, signedness irrelevant.
REQ-020 Signed A = MIN, B = -1: Quotient SHALL be MIN, Remainder 0, Overflow=1.
REQ-021 DONE SHALL hold out_valid and all results stable until out_valid & out_ready, then go to IDLE; in_ready SHALL rise the following cycle.
REQ-022 A new request SHALL NOT be accepted in the same cycle a result is consumed.
REQ-023 Input port changes after accept SHALL NOT affect the in-flight result.
REQ-024 Zero SHALL equal (Quotient==0) and be qualified by out_valid.
REQ-025 Flags SHALL be 0 whenever out_valid is 0.

Reset
REQ-026 resetn low SHALL immediately force IDLE, in_ready=1 (after release), out_valid=0, Quotient=0, Remainder=0, all flags 0, counter 0.
REQ-027 Reset mid-CALC/FIX/DONE SHALL abandon the operation with no result emitted.

Configuration
REQ-028 Macro ALU_DIV_FAST_ZERO_EN defined: B==0 SHALL bypass CALC/FIX, entering DONE directly so out_valid asserts at T+1.
REQ-029 Macro undefined: B==0 SHALL take the full T+DATA_WIDTH+2 latency; result values identical per REQ-019.

Structure
REQ-030 Shared package/header div_defs SHALL hold DATA_WIDTH default, FSM state encodings, and the signed-MIN constant.
REQ-031 One sub-module div_step SHALL implement the combinational shift/trial-subtract/select of one iteration; alu_div SHALL instantiate it once.

Verification
REQ-032 Unsigned A=100, B=7 -> Quotient=14, Remainder=2, out_valid at T+34 (DATA_WIDTH=32).
REQ-033 Signed A=-7 (0xFFFFFFF9), B=2 -> Quotient=0xFFFFFFFD, Remainder=0xFFFFFFFF, Overflow=0.
REQ-034 A=0x12345678, B=0 -> Quotient=0xFFFFFFFF, Remainder=0x12345678, DivZero=1; latency T+1 with ALU_DIV_FAST_ZERO_EN, T+34 without.
REQ-035 Signed A=0x80000000, B=0xFFFFFFFF -> Quotient=0x80000000, Remainder=0, Overflow=1.
REQ-036 A=3, B=5 with out_ready held low 10 cycles -> Quotient=0, Zero=1, Remainder=3, outputs stable throughout, in_ready=0 until cycle after consumption.
REQ-037 resetn pulsed low at T+10 of A=100,B=7 -> no out_valid; next request A=9,B=3 yields Quotient=3, Remainder=0.

Source files
------------

// File: rtl/div_defs.sv
// Shared definitions for the alu_div restoring divider: default width, FSM state codes
// and the two's-complement minimum at the default width.
package div_defs;

  localparam int unsigned DivDataWidth = 32;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [DivDataWidth-1:0] DivSignedMin = {1'b1, {(DivDataWidth-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the
// divisor, keep or restore, and shift the resulting quotient bit into the low end.
module div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_in,
  input  logic [DATA_WIDTH-1:0] dq_in,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_out,
  output logic [DATA_WIDTH-1:0] dq_out
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;
  logic                borrow;

  // dq holds the unconsumed dividend bits in its top and the quotient bits in its bottom.
  always_comb begin
    shifted = {rem_in, dq_in[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    borrow  = diff[DATA_WIDTH];
    rem_out = borrow ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    dq_out  = {dq_in[DATA_WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/alu_div.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready on both sides.
// Optional ALU_DIV_FAST_ZERO_EN: a zero divisor skips CALC/FIX and completes in one cycle.
import div_defs::*;

module alu_div #(
  parameter int unsigned DATA_WIDTH = DivDataWidth
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Quotient,
  output logic [DATA_WIDTH-1:0] Remainder,
  output logic                  DivZero,
  output logic                  Overflow,
  output logic                  Zero
);

  localparam int unsigned           CntW      = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0]       LastIter  = CntW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] SignedMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] dq_q, dq_d;
  logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic                  dz_q, dz_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] step_rem, step_dq;
  logic                  accept, a_neg, b_neg;

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem_in (rem_q),
    .dq_in  (dq_q),
    .divisor(divisor_q),
    .rem_out(step_rem),
    .dq_out (step_dq)
  );

  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid & in_ready;
  assign a_neg    = is_signed & A[DATA_WIDTH-1];
  assign b_neg    = is_signed & B[DATA_WIDTH-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dq_d      = dq_q;
    divisor_d = divisor_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          rem_d     = '0;
          dq_d      = a_neg ? -A : A;
          divisor_d = b_neg ? -B : B;
          q_neg_d   = a_neg ^ b_neg;
          r_neg_d   = a_neg;
          dz_d      = (B == '0);
          ovf_d     = is_signed & (A == SignedMin) & (B == '1);
          cnt_d     = '0;
          state_d   = StCalc;
`ifdef ALU_DIV_FAST_ZERO_EN
          if (B == '0) begin
            dq_d    = '1;
            rem_d   = A;
            state_d = StDone;
          end
`endif
        end
      end
      StCalc: begin
        rem_d = step_rem;
        dq_d  = step_dq;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // A zero divisor never subtracts, so the remainder ends as |A|; undoing the abs gives A.
        dq_d    = dz_q ? '1 : (q_neg_q ? -dq_q : dq_q);
        rem_d   = r_neg_q ? -rem_q : rem_q;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      dq_q      <= '0;
      divisor_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dq_q      <= dq_d;
      divisor_q <= divisor_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign Quotient  = out_valid ? dq_q : '0;
  assign Remainder = out_valid ? rem_q : '0;
  assign DivZero   = out_valid & dz_q;
  assign Overflow  = out_valid & ovf_q;
  assign Zero      = out_valid & (dq_q == '0);

endmodule

// File: tb/tb_alu_div.sv
// Randomised self-checking bench for alu_div against a plain-arithmetic division model.
module tb_alu_div;
  import div_defs::*;

  localparam int unsigned W = 32;
`ifdef ALU_DIV_FAST_ZERO_EN
  localparam bit FastZero = 1'b1;
`else
  localparam bit FastZero = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn, in_valid, is_signed, out_ready;
  logic [W-1:0] A, B, Quotient, Remainder;
  logic         in_ready, out_valid, DivZero, Overflow, Zero;

  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           due = 0;
  bit           chk_en = 1'b0;
  bit           in_flight = 1'b0;
  logic [W-1:0] exp_q, exp_r;
  bit           exp_dz, exp_ov;

  alu_div #(
    .DATA_WIDTH(W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .DivZero  (DivZero),
    .Overflow (Overflow),
    .Zero     (Zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: division defined by plain integer arithmetic on 64-bit values.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output bit dz, output bit ov);
    longint sa, sb;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      ov = (a == DivSignedMin) && (b == '1);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  always @(negedge clk) begin
    bit want;
    if (chk_en) begin
      if (in_flight) begin
        want = (cyc >= due);
        chk("out_valid", out_valid, want);
        chk("in_ready_busy", in_ready, 0);
        if (want) begin
          chk("Quotient", Quotient, exp_q);
          chk("Remainder", Remainder, exp_r);
          chk("DivZero", DivZero, exp_dz);
          chk("Overflow", Overflow, exp_ov);
          chk("Zero", Zero, exp_q == 0);
        end else begin
          chk("flags_pending", {DivZero, Overflow, Zero}, 0);
        end
      end else begin
        chk("out_valid_idle", out_valid, 0);
        chk("in_ready_idle", in_ready, 1);
        chk("Quotient_idle", Quotient, 0);
        chk("Remainder_idle", Remainder, 0);
        chk("flags_idle", {DivZero, Overflow, Zero}, 0);
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after consumption.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                       input int hold, input bit lit, input logic [W-1:0] lq,
                       input logic [W-1:0] lr);
    int lat;
    model(a, b, s, exp_q, exp_r, exp_dz, exp_ov);
    A = a;
    B = b;
    is_signed = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    A         = $urandom;
    B         = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    lat       = (FastZero && b == 0) ? 0 : W + 1;
    due       = cyc + lat;
    in_flight = 1'b1;
    if (lat > 0) begin
      repeat (lat) @(posedge clk);
      #1;
    end
    if (lit) begin
      chk("lit_Quotient", Quotient, lq);
      chk("lit_Remainder", Remainder, lr);
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_flight = 1'b0;
  endtask

  initial begin
    logic [W-1:0] q, r, a, b;
    bit           dz, ov, s;
    int           kind;

    resetn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    is_signed = 1'b0;

    model(100, 7, 0, q, r, dz, ov);
    chk("pin_udiv_q", q, 14);
    chk("pin_udiv_r", r, 2);
    model(32'hFFFF_FFF9, 2, 1, q, r, dz, ov);
    chk("pin_sdiv_q", q, 32'hFFFF_FFFD);
    chk("pin_sdiv_r", r, 32'hFFFF_FFFF);
    model(32'h8000_0000, 32'hFFFF_FFFF, 1, q, r, dz, ov);
    chk("pin_ovf_q", q, 32'h8000_0000);
    chk("pin_ovf_flag", ov, 1);
    model(32'h1234_5678, 0, 1, q, r, dz, ov);
    chk("pin_dz_r", r, 32'h1234_5678);
    chk("pin_dz_flag", dz, 1);

    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    do_op(100, 7, 0, 0, 1, 14, 2);
    do_op(32'hFFFF_FFF9, 2, 1, 1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_op(32'h1234_5678, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'h1234_5678);
    do_op(32'h1234_5678, 0, 1, 2, 1, 32'hFFFF_FFFF, 32'h1234_5678);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1, 32'h8000_0000, 0);
    do_op(3, 5, 0, 10, 1, 0, 3);
    do_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1, 0, 1, 3, 32'hFFFF_FFFF);

    // Abandon an in-flight divide with a reset pulse in cycle T+10.
    A = 100;
    B = 7;
    is_signed = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    due       = cyc + 100000;
    in_flight = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    resetn    = 1'b0;
    in_flight = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (W + 5) @(posedge clk);
    #1;
    do_op(9, 3, 0, 0, 1, 3, 0);

    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 9));
      s    = 1'($urandom_range(0, 1));
      a    = $urandom;
      b    = $urandom;
      if (kind == 0) b = '0;
      if (kind == 1) begin
        a = DivSignedMin;
        b = '1;
        s = 1'b1;
      end
      if (kind == 2) b = $urandom_range(1, 15);
      if (kind == 3) b = -$urandom_range(1, 15);
      if (kind == 4) a = $urandom_range(0, 40);
      do_op(a, b, s, int'($urandom_range(0, 3)), 1'b0, '0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
